// File: rtl/complex_pkg.sv
// complex_pkg
// Shared definitions for the complex add/sub scheduler slice:
//   CPLX_W  - width of one complex word {real[63:32], imag[31:0]}
//   LANE_W  - width of one single-precision lane
//   OP_ADD / OP_SUB - op encodings presented to the shared adder
//   sched_state_t   - scheduler state (RUN accepts work, DRAIN empties the pipe)
package complex_pkg;

  localparam int CPLX_W = 64;
  localparam int LANE_W = 32;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } sched_state_t;

endpackage

// File: rtl/addsub_tag_pipe.sv
// addsub_tag_pipe
// LATENCY-deep shift register of {valid, id} tags that advances in lock-step
// with the shared adder pipeline, so each result can be routed back to the
// requester that issued it.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   en                    - shift enable (mirrors the adder clock enable)
//   in_valid, in_id       - tag entering stage 0 (valid=0 inserts a bubble)
//   last_valid, last_id   - tag in the final stage
//   any_valid             - at least one stage holds a live tag
module addsub_tag_pipe
  import complex_pkg::*;
#(
  parameter int LATENCY = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic in_valid,
  input  logic in_id,
  output logic last_valid,
  output logic last_id,
  output logic any_valid
);

  logic [LATENCY-1:0] stage_valid;
  logic [LATENCY-1:0] stage_id;

  // Tags only move when the adder pipeline moves; otherwise they hold so the
  // tag that reaches the last stage always lines up with addsub_result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_valid <= '0;
      stage_id    <= '0;
    end else if (en) begin
      stage_valid[0] <= in_valid;
      stage_id[0]    <= in_id;
      for (int i = 1; i < LATENCY; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_id[i]    <= stage_id[i-1];
      end
    end
  end

  assign last_valid = stage_valid[LATENCY-1];
  assign last_id    = stage_id[LATENCY-1];
  assign any_valid  = |stage_valid;

endmodule

// File: rtl/complex_addsub_scheduler.sv
// complex_addsub_scheduler
// Shares one pipelined complex adder/subtractor between two requesters with
// round-robin arbitration, returns each result to its issuer, gates the adder
// clock enable, and supports a flush/drain handshake.
// Ports:
//   clk, rst_n                       - clock, synchronous active-low reset
//   reqN_valid/ready/a/b/op (N=0,1)  - request channels, ready = grant
//   flush / flush_done               - drain request pulse / completion pulse
//   addsub_a/b/op/ce, addsub_result  - shared adder interface
//   rsp_valid/id/data                - result pulse tagged with requester index
//   last_result                      - most recent result, held
//   busy                             - work in flight or draining
module complex_addsub_scheduler
  import complex_pkg::*;
#(
  parameter int LATENCY = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CPLX_W-1:0] req0_a,
  input  logic [CPLX_W-1:0] req0_b,
  input  logic              req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CPLX_W-1:0] req1_a,
  input  logic [CPLX_W-1:0] req1_b,
  input  logic              req1_op,
  input  logic              flush,
  output logic              flush_done,
  output logic [CPLX_W-1:0] addsub_a,
  output logic [CPLX_W-1:0] addsub_b,
  output logic              addsub_op,
  output logic              addsub_ce,
  input  logic [CPLX_W-1:0] addsub_result,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [CPLX_W-1:0] rsp_data,
  output logic [CPLX_W-1:0] last_result,
  output logic              busy
);

  localparam int CNT_W = $clog2(LATENCY + 2);

  sched_state_t     state;
  logic             rr;
  logic [CNT_W-1:0] inflight;
  logic             grant0;
  logic             grant1;
  logic             transfer;
  logic             capture;
  logic             tag_last_valid;
  logic             tag_last_id;
  logic             tag_any_valid;

  // Round-robin grant: an uncontested requester always wins; when both ask,
  // rr (0 = req0) picks. Nothing is granted while draining or in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && state == RUN) begin
      grant0 = req0_valid && (!req1_valid || !rr);
      grant1 = req1_valid && (!req0_valid || rr);
    end
  end

  assign transfer   = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // The adder runs whenever new work enters or live tags remain, so an idle
  // pipe costs no switching; capture fires as the oldest tag leaves the pipe.
  assign addsub_ce = rst_n && (transfer || tag_any_valid);
  assign capture   = addsub_ce && tag_last_valid;

  // Operands are driven only on a transfer and are zero otherwise.
  always_comb begin
    addsub_a  = '0;
    addsub_b  = '0;
    addsub_op = OP_ADD;
    if (grant1) begin
      addsub_a  = req1_a;
      addsub_b  = req1_b;
      addsub_op = req1_op;
    end else if (grant0) begin
      addsub_a  = req0_a;
      addsub_b  = req0_b;
      addsub_op = req0_op;
    end
  end

  assign busy = (inflight != '0) || (state != RUN);

  addsub_tag_pipe #(
    .LATENCY(LATENCY)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (addsub_ce),
    .in_valid  (transfer),
    .in_id     (grant1),
    .last_valid(tag_last_valid),
    .last_id   (tag_last_id),
    .any_valid (tag_any_valid)
  );

  // Scheduler state, round-robin pointer, in-flight count and registered
  // response outputs. rr only moves on a contested grant and then points at
  // the loser. DRAIN exits once the count reaches zero, pulsing flush_done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      rr          <= 1'b0;
      inflight    <= '0;
      flush_done  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_data    <= '0;
      last_result <= '0;
    end else begin
      flush_done <= 1'b0;
      rsp_valid  <= capture;
      if (capture) begin
        rsp_id      <= tag_last_id;
        rsp_data    <= addsub_result;
        last_result <= addsub_result;
      end
      if (transfer && req0_valid && req1_valid) begin
        rr <= grant0;
      end
      if (transfer && !capture) begin
        inflight <= inflight + CNT_W'(1);
      end else if (!transfer && capture) begin
        inflight <= inflight - CNT_W'(1);
      end
      case (state)
        RUN: begin
          if (flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (inflight == '0) begin
            flush_done <= 1'b1;
            state      <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_addsub_scheduler.sv
// tb_complex_addsub_scheduler
// Directed bench for complex_addsub_scheduler with LATENCY = 4. A behavioural
// single-precision adder stands in for the shared adder instance; a
// scoreboard predicts every response's cycle, id and data.
module tb_complex_addsub_scheduler;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_op, req1_op;
  logic        flush, flush_done;
  logic [63:0] addsub_a, addsub_b, addsub_result;
  logic        addsub_op, addsub_ce;
  logic        rsp_valid, rsp_id;
  logic [63:0] rsp_data, last_result;
  logic        busy;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;

  typedef struct {
    int          due;
    logic        id;
    logic [63:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        v0, v1;
    logic [63:0] a0, b0, a1, b1;
    logic        op0, op1;
    logic        e0, e1;
  } vec_t;
  vec_t vecs[16];

  logic [63:0] adder_pipe[LAT];

  complex_addsub_scheduler #(.LATENCY(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_op      (req0_op),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_op      (req1_op),
    .flush        (flush),
    .flush_done   (flush_done),
    .addsub_a     (addsub_a),
    .addsub_b     (addsub_b),
    .addsub_op    (addsub_op),
    .addsub_ce    (addsub_ce),
    .addsub_result(addsub_result),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .last_result  (last_result),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic real f2r(input logic [31:0] x);
    real r;
    int  e;
    if (x[30:0] == 31'd0) return 0.0;
    r = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return x[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    real         a;
    int          e;
    logic        s;
    logic [22:0] m;
    if (r == 0.0) return 32'd0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m = 23'($rtoi((a - 1.0) * 8388608.0));
    return {s, 8'(e), m};
  endfunction

  function automatic logic [63:0] add_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic op);
    real re, im;
    re = op ? f2r(a[63:32]) - f2r(b[63:32]) : f2r(a[63:32]) + f2r(b[63:32]);
    im = op ? f2r(a[31:0]) - f2r(b[31:0]) : f2r(a[31:0]) + f2r(b[31:0]);
    return {r2f(re), r2f(im)};
  endfunction

  // Behavioural shared adder: LAT ce-enabled stages from operand sample.
  always @(posedge clk) begin
    if (addsub_ce) begin
      adder_pipe[0] <= add_model(addsub_a, addsub_b, addsub_op);
      for (int i = 1; i < LAT; i++) adder_pipe[i] <= adder_pipe[i-1];
    end
  end
  assign addsub_result = adder_pipe[LAT-1];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic v1,
                               input logic [63:0] a0, input logic [63:0] b0, input logic op0,
                               input logic [63:0] a1, input logic [63:0] b1, input logic op1,
                               input logic fl);
    req0_valid = v0;
    req1_valid = v1;
    req0_a     = a0;
    req0_b     = b0;
    req0_op    = op0;
    req1_a     = a1;
    req1_b     = b1;
    req1_op    = op1;
    flush      = fl;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    nextCycle();
    applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  // Scoreboard: records each transfer with its due cycle and checks every
  // cycle that rsp_valid appears exactly when due, with matching id and data.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      checkOutput("single_grant", 64'(req0_ready & req1_ready), 64'd0);
      if (req0_valid && req0_ready) begin
        checkOutput("issue0_a", addsub_a, req0_a);
        checkOutput("issue0_op", 64'(addsub_op), 64'(req0_op));
        sb.push_back('{cyc + LAT + 1, 1'b0, add_model(req0_a, req0_b, req0_op)});
      end
      if (req1_valid && req1_ready) begin
        checkOutput("issue1_b", addsub_b, req1_b);
        checkOutput("issue1_op", 64'(addsub_op), 64'(req1_op));
        sb.push_back('{cyc + LAT + 1, 1'b1, add_model(req1_a, req1_b, req1_op)});
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        checkOutput("rsp_valid", 64'(rsp_valid), 64'd1);
        checkOutput("rsp_id", 64'(rsp_id), 64'(sb[0].id));
        checkOutput("rsp_data", rsp_data, sb[0].data);
        void'(sb.pop_front());
      end else begin
        checkOutput("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end
    end
  end

  initial begin
    logic [63:0] op_a, op_b;
    bit v0_pat[16] = '{1,1,1,1,1,1,0,0,0,1,1,0,1,1,0,1};
    bit v1_pat[16] = '{1,1,1,1,1,1,1,1,1,1,1,0,0,1,1,1};
    bit e0_pat[16] = '{1,0,1,0,1,0,0,0,0,1,0,0,1,1,0,0};
    bit e1_pat[16] = '{0,1,0,1,0,1,1,1,1,0,1,0,0,0,1,1};
    int n;

    for (int i = 0; i < 16; i++) begin
      vecs[i].v0  = v0_pat[i];
      vecs[i].v1  = v1_pat[i];
      vecs[i].a0  = {r2f(real'(i + 1)), r2f(real'(i + 2))};
      vecs[i].b0  = {r2f(0.5), r2f(real'(i))};
      vecs[i].op0 = i[0];
      vecs[i].a1  = {r2f(real'(10 + i)), r2f(4.0)};
      vecs[i].b1  = {r2f(1.5), r2f(real'(3 * i))};
      vecs[i].op1 = ~i[0];
      vecs[i].e0  = e0_pat[i];
      vecs[i].e1  = e1_pat[i];
    end

    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 64'd1, 64'd2, 1'b0, 64'd3, 64'd4, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_last_result", last_result, 64'd0);
    checkOutput("reset_flush_done", 64'(flush_done), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_ready0", 64'(req0_ready), 64'd0);
    checkOutput("reset_ce", 64'(addsub_ce), 64'd0);
    checkOutput("reset_addsub_a", addsub_a, 64'd0);
    nextCycle();
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("idle_ce_after_reset", 64'(addsub_ce), 64'd0);

    $display("[TB] single operation latency");
    op_a = 64'h3F800000_40000000;
    op_b = 64'h40000000_3F800000;
    nextCycle();
    applyStimulus(1'b1, 1'b0, op_a, op_b, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("single_ready0", 64'(req0_ready), 64'd1);
    checkOutput("single_ce", 64'(addsub_ce), 64'd1);
    for (int k = 1; k <= 7; k++) begin
      idleCycle();
      if (k == LAT + 1) begin
        checkOutput("single_rsp_valid", 64'(rsp_valid), 64'd1);
        checkOutput("single_rsp_id", 64'(rsp_id), 64'd0);
        checkOutput("single_rsp_data", rsp_data, 64'h40400000_40400000);
      end
      if (k > LAT + 1) begin
        checkOutput("single_last_result", last_result, 64'h40400000_40400000);
        checkOutput("single_rsp_gone", 64'(rsp_valid), 64'd0);
      end
    end

    $display("[TB] arbitration vectors");
    for (int i = 0; i < 16; i++) begin
      nextCycle();
      applyStimulus(vecs[i].v0, vecs[i].v1, vecs[i].a0, vecs[i].b0, vecs[i].op0,
                    vecs[i].a1, vecs[i].b1, vecs[i].op1, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_ready0", i), 64'(req0_ready), 64'(vecs[i].e0));
      checkOutput($sformatf("vec%0d_ready1", i), 64'(req1_ready), 64'(vecs[i].e1));
    end

    idleCycle();
    n = 0;
    while (busy && n < 30) begin
      idleCycle();
      n++;
    end
    checkOutput("drain_wait_busy", 64'(busy), 64'd0);

    $display("[TB] idle clock gating");
    for (int k = 0; k < 10; k++) begin
      idleCycle();
      checkOutput("idle_ce", 64'(addsub_ce), 64'd0);
      checkOutput("idle_busy", 64'(busy), 64'd0);
    end

    $display("[TB] flush with empty pipe");
    nextCycle();
    applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("eflush_busy0", 64'(busy), 64'd0);
    idleCycle();
    checkOutput("eflush_busy1", 64'(busy), 64'd1);
    checkOutput("eflush_done1", 64'(flush_done), 64'd0);
    idleCycle();
    checkOutput("eflush_done2", 64'(flush_done), 64'd1);
    checkOutput("eflush_busy2", 64'(busy), 64'd0);
    idleCycle();
    checkOutput("eflush_done3", 64'(flush_done), 64'd0);

    $display("[TB] flush with three in flight");
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      applyStimulus(1'b1, 1'b0, {r2f(real'(k)), r2f(8.0)}, {r2f(2.0), r2f(real'(k))},
                    1'b1, 64'd0, 64'd0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("dflush_issue_ready0", 64'(req0_ready), 64'd1);
    end
    nextCycle();
    applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("dflush_pulse_done", 64'(flush_done), 64'd0);
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      applyStimulus(1'b1, 1'b0, {r2f(7.0), r2f(1.0)}, {r2f(1.0), r2f(1.0)},
                    1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("dflush_blocked_ready0", 64'(req0_ready), 64'd0);
      checkOutput("dflush_wait_done", 64'(flush_done), 64'd0);
      checkOutput("dflush_busy", 64'(busy), 64'd1);
    end
    nextCycle();
    @(negedge clk);
    checkOutput("dflush_done", 64'(flush_done), 64'd1);
    checkOutput("dflush_run_ready0", 64'(req0_ready), 64'd1);
    idleCycle();
    checkOutput("dflush_done_pulse", 64'(flush_done), 64'd0);

    $display("[TB] reset with work in flight");
    for (int k = 0; k < 2; k++) begin
      nextCycle();
      applyStimulus(1'b1, 1'b0, {r2f(3.0), r2f(5.0)}, {r2f(1.0), r2f(real'(k))},
                    1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("rst_issue_ready0", 64'(req0_ready), 64'd1);
    end
    nextCycle();
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_ready0_gated", 64'(req0_ready), 64'd0);
    checkOutput("rst_ce_gated", 64'(addsub_ce), 64'd0);
    checkOutput("rst_a_gated", addsub_a, 64'd0);
    nextCycle();
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_last_result", last_result, 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    for (int k = 0; k < 8; k++) begin
      idleCycle();
      checkOutput("rst_after_ce", 64'(addsub_ce), 64'd0);
      checkOutput("rst_after_busy", 64'(busy), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
